mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter peripheral on the DLX data bus, alongside the data RAM and the LED peripheral.
- The CPU writes bytes into an internal FIFO. The block serialises them 8N1, LSB first, on a single tx line.
- Status and baud-divisor registers are readable and writable by the CPU.
- Read timing matches the data RAM: one-cycle latency, with a rdata_valid pulse.

---
 rtl/mmio_uart_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter on the DLX data bus.
//
// The CPU pushes bytes into a small FIFO through the DATA register. A
// transmit FSM pops them one at a time and sends each as an 8N1 frame, LSB
// first, on tx. The baud divisor (clocks per bit) is CPU-programmable and is
// sampled once per frame. Reads behave like the data RAM: data_read is
// registered on the access edge and qualified by a one-cycle rdata_valid.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   cs           chip select from the bus decoder
//   addr         word offset: 0 DATA, 1 STATUS, 2 DIV, 3 reserved
//   write_enable bus write strobe (read when low and cs is high)
//   data_write   bus write data
//   data_read    registered read data, holds between reads
//   rdata_valid  one-cycle pulse qualifying data_read
//   tx           serial output, idle high, registered
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        rdata_valid,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Bus decode
  logic wr_access, rd_access, push_req, push_ok, pop;
  logic full, empty, busy;
  logic [3:0] count_sat;
  logic unused_bits;

  // Registers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   div_q, div_d;
  logic [31:0]   data_read_q, data_read_d;
  logic          rdata_valid_q, rdata_valid_d;

  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   div_lat_q, div_lat_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last;

  assign unused_bits = ^data_write[31:16];

  assign wr_access = cs & write_enable;
  assign rd_access = cs & ~write_enable;
  assign push_req  = wr_access && (addr == A_DATA);

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign busy  = (state_q != S_IDLE);

  // The FSM only ever pops from IDLE, so a pop is exactly "IDLE and data waiting".
  assign pop = (state_q == S_IDLE) && !empty;

  // A push into a full FIFO still lands if the same edge pops the head.
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    if (32'(count_q) > 32'd15) count_sat = 4'd15;
    else                       count_sat = 4'(count_q);
  end

  // ---------------------------------------------------------------------
  // FIFO bookkeeping and CPU-visible registers
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    div_d         = div_q;
    data_read_d   = data_read_q;
    rdata_valid_d = rd_access;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) overflow_d = 1'b1;
    if (wr_access && (addr == A_STATUS) && data_write[3]) overflow_d = 1'b0;

    // Divisors below 2 would leave no room for the baud counter to count.
    if (wr_access && (addr == A_DIV)) begin
      if (data_write[15:0] < 16'd2) div_d = 16'd2;
      else                          div_d = data_write[15:0];
    end

    // Read mux uses current register values, i.e. state before this edge.
    if (rd_access) begin
      case (addr)
        A_STATUS: data_read_d = {24'd0, count_sat, overflow_q, busy, empty, full};
        A_DIV:    data_read_d = {16'd0, div_q};
        default:  data_read_d = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  assign baud_last = (baud_q == div_lat_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_lat_d = div_lat_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d   = mem_q[rd_ptr_q];
          div_lat_d = div_q;
          baud_d    = 16'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d    = 16'd0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx follows the current state one clock later, so the line is driven
  // straight from a flop and cannot glitch.
  always_comb begin
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      div_q         <= 16'(DEFAULT_DIV);
      data_read_q   <= 32'd0;
      rdata_valid_q <= 1'b0;
      state_q       <= S_IDLE;
      baud_q        <= 16'd0;
      div_lat_q     <= 16'(DEFAULT_DIV);
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'd0;
      tx_q          <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      div_q         <= div_d;
      data_read_q   <= data_read_d;
      rdata_valid_q <= rdata_valid_d;
      state_q       <= state_d;
      baud_q        <= baud_d;
      div_lat_q     <= div_lat_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only ever read after a
  // push has written them, and the count/pointers that guard them are reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_write[7:0];
  end

  assign data_read   = data_read_q;
  assign rdata_valid = rdata_valid_q;
  assign tx          = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Bytes written to DATA are pushed to a
// scoreboard queue; a serial receiver decodes each frame on tx, checks its
// bit timing against the expected divisor and compares the byte against the
// queue head.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset_n;
  logic        cs;
  logic [1:0]  addr;
  logic        write_enable;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        rdata_valid;
  logic        tx;

  int n_checks;
  int n_fail;
  logic [7:0] sb[$];

  mmio_uart_tx #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(434)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs          (cs),
    .addr        (addr),
    .write_enable(write_enable),
    .data_write  (data_write),
    .data_read   (data_read),
    .rdata_valid (rdata_valid),
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus tasks: called just after a negedge, return just after a negedge, so
  // consecutive calls produce accesses on consecutive rising edges.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write_enable = 1'b1; addr = a; data_write = d;
    @(negedge clk);
    cs = 1'b0; write_enable = 1'b0;
  endtask

  task automatic push_data(input logic [7:0] b);
    sb.push_back(b);
    bus_write(2'd0, {24'd0, b});
  endtask

  // v1 is rdata_valid in the cycle after the read edge, v2 the cycle after that.
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d,
                          output logic v1, output logic v2);
    cs = 1'b1; write_enable = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d  = data_read;
    v1 = rdata_valid;
    @(negedge clk);
    v2 = rdata_valid;
  endtask

  // Receiver + scoreboard: waits for a start bit (exp_wait > 0 also checks how
  // many negedges it took), samples every cycle of the frame at div cycles/bit
  // and compares the decoded byte against the scoreboard head.
  task automatic expect_frame(input int div, input int exp_wait, input string name);
    int w;
    int bad;
    logic [7:0] got;
    logic [7:0] exp_b;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx !== 1'b0 && w < 3000);
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: tx=%b after %0d cycles, required start bit 0", name, tx, w);
      return;
    end
    if (exp_wait > 0) begin
      n_checks++;
      if (w != exp_wait) begin
        n_fail++;
        $display("FAIL %s_latency: start bit after %0d cycles, required %0d", name, w, exp_wait);
      end
    end
    bad = 0;
    got = 8'd0;
    for (int c = 1; c < div; c++) begin
      @(negedge clk);
      if (tx !== 1'b0) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got[i] = tx;
      for (int c = 1; c < div; c++) begin
        @(negedge clk);
        if (tx !== got[i]) bad++;
      end
    end
    for (int c = 0; c < div; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    n_checks++;
    if (got !== exp_b) begin
      n_fail++;
      $display("FAIL %s_byte: got %h required %h", name, got, exp_b);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_timing: %0d cycles deviate from %0d cycles/bit framing", name, bad, div);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v1, v2;
    int tx_bad;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || rdata_valid !== 1'b0 || data_read !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: tx=%b valid=%b data=%h required 1 0 00000000",
               tx, rdata_valid, data_read);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tx_bad = (tx !== 1'b1) ? 1 : 0;
    bus_read(2'd1, d, v1, v2);
    if (tx !== 1'b1) tx_bad++;
    n_checks++;
    if (d !== 32'h0000_0002 || v1 !== 1'b1 || v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: data=%h valid=%b,%b required 00000002 valid=1,0", d, v1, v2);
    end
    bus_read(2'd2, d, v1, v2);
    if (tx !== 1'b1) tx_bad++;
    n_checks++;
    if (d !== 32'd434 || v1 !== 1'b1 || v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_div: data=%h valid=%b,%b required %h valid=1,0", d, v1, v2, 32'd434);
    end
    n_checks++;
    if (tx_bad != 0) begin
      n_fail++;
      $display("FAIL reset_tx_idle: %0d samples low, required 0", tx_bad);
    end
    // data_read holds its last value while no read is in progress
    repeat (2) @(negedge clk);
    n_checks++;
    if (data_read !== 32'd434) begin
      n_fail++;
      $display("FAIL read_hold: data=%h required %h", data_read, 32'd434);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic v1, v2;
    bus_write(2'd2, 32'd4);
    fork
      begin
        push_data(8'h55);
        repeat (10) @(negedge clk);
        bus_read(2'd1, d, v1, v2);
        n_checks++;
        // count 0 (already popped), empty, busy
        if (d !== 32'h0000_0006 || v1 !== 1'b1) begin
          n_fail++;
          $display("FAIL single_busy: status=%h valid=%b required 00000006 valid=1", d, v1);
        end
      end
      expect_frame(4, 3, "single");
    join
    bus_read(2'd1, d, v1, v2);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL single_idle: status=%h required 00000002", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v1, v2;
    fork
      begin
        push_data(8'h01);
        push_data(8'h02);
        push_data(8'h03);
        // The first byte is popped one edge after it is written, so the count
        // peaks at 2 and then drops by one as each further frame starts.
        bus_read(2'd1, d, v1, v2);
        n_checks++;
        if (d !== 32'h0000_0024) begin
          n_fail++;
          $display("FAIL b2b_count2: status=%h required 00000024", d);
        end
        repeat (56) @(negedge clk);
        bus_read(2'd1, d, v1, v2);
        n_checks++;
        if (d !== 32'h0000_0014) begin
          n_fail++;
          $display("FAIL b2b_count1: status=%h required 00000014", d);
        end
        repeat (40) @(negedge clk);
        bus_read(2'd1, d, v1, v2);
        n_checks++;
        if (d !== 32'h0000_0006) begin
          n_fail++;
          $display("FAIL b2b_count0: status=%h required 00000006", d);
        end
      end
      begin
        expect_frame(4, 3, "b2b_f1");
        expect_frame(4, 2, "b2b_f2");
        expect_frame(4, 2, "b2b_f3");
      end
    join
    bus_read(2'd1, d, v1, v2);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL b2b_idle: status=%h required 00000002", d);
    end
  endtask

  task automatic test_divisor();
    logic [31:0] d;
    logic v1, v2;
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, d, v1, v2);
    n_checks++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL div_clamp: div=%h required %h", d, 32'd2);
    end
    bus_write(2'd2, 32'hABCD_0004);
    fork
      begin
        push_data(8'hA5);
        push_data(8'h3C);
        repeat (10) @(negedge clk);
        bus_write(2'd2, 32'd8);
      end
      begin
        expect_frame(4, 3, "div_old");
        expect_frame(8, 2, "div_new");
      end
    join
    bus_read(2'd2, d, v1, v2);
    n_checks++;
    if (d !== 32'd8) begin
      n_fail++;
      $display("FAIL div_readback: div=%h required %h", d, 32'd8);
    end
  endtask

  task automatic test_overflow_and_reset();
    logic [31:0] d;
    logic v1, v2;
    int tx_bad;
    bus_write(2'd2, 32'd1000);
    // Byte 0 is 0x00 so the DATA state holds tx low for a long stretch.
    for (int i = 0; i < 9; i++) push_data(8'(i * 17));
    bus_write(2'd0, 32'h0000_00EE);  // FIFO full, FSM mid-frame: dropped
    bus_read(2'd1, d, v1, v2);
    n_checks++;
    if (d !== 32'h0000_008D) begin
      n_fail++;
      $display("FAIL ovf_status: status=%h required 0000008D", d);
    end
    bus_write(2'd1, 32'h0000_0008);
    bus_read(2'd1, d, v1, v2);
    n_checks++;
    if (d !== 32'h0000_0085) begin
      n_fail++;
      $display("FAIL ovf_clear: status=%h required 00000085", d);
    end
    // Land inside the DATA state of the stalled first frame (byte 0x00).
    repeat (1500) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_tx: tx=%b required 0", tx);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_tx: tx=%b required 1", tx);
    end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d, v1, v2);
    n_checks++;
    if (d !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL post_reset_status: status=%h required 00000002", d);
    end
    tx_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_bad++;
    end
    n_checks++;
    if (tx_bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: %0d samples low, required 0", tx_bad);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    cs           = 1'b0;
    addr         = 2'd0;
    write_enable = 1'b0;
    data_write   = 32'd0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_divisor();
    test_overflow_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
